lfsr_prbs_checker: RTL and testbench
====================================

// Module: lfsr_prbs_checker
// PURPOSE
//  Receive-side counterpart of the LFSR PRNG: consumes a stream of NUM_BITS-wide LFSR state words,
//  self-seeds a local LFSR from the first valid word, predicts each following word and counts
//  mismatches. Used for PRNG link/bring-up checking and as the lock detector ahead of keystream consumers.
// PARAMETERS
//  NUM_BITS     8      LFSR width (3..32)
//  TAPS         8'hB8  feedback tap mask, bit i = state[i] tapped (default x^8+x^6+x^5+x^4+1)
//  LOSS_THRESH  4      consecutive mismatches that drop lock (1..15)
//  CNT_W        16     width of error and word counters
// PORTS
//  i_Clk          in   1         clock, all logic on rising edge
//  i_Rst_L        in   1         synchronous reset, active low
//  i_Clear        in   1         pulse: zero counters, return to ACQUIRE (same as reset, except no port effect)
//  i_Data_DV      in   1         i_Data valid this cycle
//  i_Data         in   NUM_BITS  received LFSR state word
//  o_Locked       out  1         high in CHECK state
//  o_Err          out  1         one-cycle pulse: checked word mismatched prediction
//  o_Err_Count    out  CNT_W     mismatches since lock/clear, saturating
//  o_Word_Count   out  CNT_W     words checked since lock/clear, saturating
//  o_Period_Done  out  1         one-cycle pulse: checked word equals lock seed (full period observed)
// BEHAVIOUR
//  Next-state fn: nxt(s) = {s[NUM_BITS-2:0], ~^(s & TAPS)} (XNOR feedback, shift toward MSB).
//  All-ones is the XNOR lockup word: never accepted as seed; in CHECK it is compared like any word.
//  Reset / i_Clear (both sync, i_Rst_L dominates): state=ACQUIRE, all outputs 0, predictor=0, seed=0,
//   miss-run=0. i_Clear ignores i_Data_DV that cycle.
//  ACQUIRE: on i_Data_DV and i_Data != all-ones -> seed<=i_Data, pred<=nxt(i_Data), counters<=0,
//   go CHECK. No o_Err, no counting in ACQUIRE. No DV -> stay.
//  CHECK (o_Locked=1): on i_Data_DV compare i_Data to pred; pred<=nxt(i_Data) on match,
//   pred<=nxt(pred) on mismatch (flywheel; a single bit slip does not re-seed).
//   Word_Count+1 every DV; match: miss-run<=0; mismatch: o_Err=1 next cycle, Err_Count+1, miss-run+1.
//   When miss-run reaches LOSS_THRESH -> ACQUIRE same edge; Err_Count/Word_Count hold (sticky until
//   next lock or clear), o_Locked falls next cycle.
//   Match and i_Data==seed -> o_Period_Done pulse (first pulse after exactly 2^NUM_BITS-1 words for a
//   maximal TAPS).
//  No DV -> nothing changes; gaps of any length are legal, prediction advances only per valid word.
//  Latency: all outputs registered, 1 cycle after the DV edge. Counters saturate at all-ones, no wrap.
//  Err pulse and Period_Done mutually exclusive (period needs match).
// STRUCTURE
//  Shared pkg (crypto_pkg): lfsr_next() function (width, taps), default TAPS per width table,
//   checker state enum {ACQUIRE, CHECK}. Same lfsr_next() must be used by the PRNG to stay bit-exact.
//  One sub-module natural: sat_counter (CNT_W, inc, clr) instantiated twice. FSM + compare inline.
// TESTING
//  1 PRNG seed 8'h01 -> DUT, DV every cycle: Locked=1 after 1st word, Err_Count=0, Period_Done
//    pulses on word 255 after lock, again at 510.
//  2 Flip bit 0 of one word mid-stream: exactly one o_Err, Err_Count=1, Locked stays 1, next words match.
//  3 Feed 4 consecutive wrong words (LOSS_THRESH=4): Err_Count=4, Locked falls, next good word
//    re-locks and counters restart at 0.
//  4 First word 8'hFF then 8'h5A: stays ACQUIRE on FF, locks on 5A; DV gaps of 0..7 cycles random
//    -> zero errors.
//  5 Force 70000 mismatches with LOSS_THRESH=15 alternating good words: Err_Count saturates 16'hFFFF.
//  6 i_Rst_L low and i_Clear mid-CHECK with DV high: outputs 0 next cycle, that word not counted.

Source files
------------

// File: rtl/crypto_pkg.sv
// Shared LFSR helpers and checker state type. The PRNG and the checker must both use
// lfsr_next() so that the generated and predicted sequences stay bit-exact.
package crypto_pkg;

   localparam int MISS_W = 4;

   typedef enum logic {
      ACQUIRE = 1'b0,
      CHECK   = 1'b1
   } chk_state_t;

   // XNOR-feedback LFSR step: shift toward the MSB, feedback into bit 0.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                             input logic [31:0] taps,
                                             input int          width);
      logic [31:0] mask;
      logic        fb;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      fb   = ~^(s & taps & mask);
      return ((s << 1) | {31'd0, fb}) & mask;
   endfunction

   // Maximal-length tap masks, bit i set when state[i] feeds back.
   function automatic logic [31:0] default_taps(input int width);
      logic [31:0] t;
      case (width)
         3:       t = 32'h0000_0006;
         4:       t = 32'h0000_000C;
         5:       t = 32'h0000_0014;
         6:       t = 32'h0000_0030;
         7:       t = 32'h0000_0060;
         8:       t = 32'h0000_00B8;
         9:       t = 32'h0000_0110;
         10:      t = 32'h0000_0240;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0829;
         13:      t = 32'h0000_100D;
         14:      t = 32'h0000_2015;
         15:      t = 32'h0000_6000;
         16:      t = 32'h0000_D008;
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         19:      t = 32'h0004_0023;
         20:      t = 32'h0009_0000;
         21:      t = 32'h0014_0000;
         22:      t = 32'h0030_0000;
         23:      t = 32'h0042_0000;
         24:      t = 32'h00E1_0000;
         25:      t = 32'h0120_0000;
         26:      t = 32'h0200_0023;
         27:      t = 32'h0400_0013;
         28:      t = 32'h0900_0000;
         29:      t = 32'h1400_0000;
         30:      t = 32'h2000_0029;
         31:      t = 32'h4800_0000;
         32:      t = 32'h8020_0003;
         default: t = 32'h0000_00B8;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr beats inc.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!rst_l || clr) begin
         count <= '0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-seeding LFSR stream checker: locks on the first usable word, then predicts and
// scores every following valid word, dropping lock after a run of mismatches.
module lfsr_prbs_checker
   import crypto_pkg::*;
#(
   parameter int                  NUM_BITS    = 8,
   parameter logic [NUM_BITS-1:0] TAPS        = NUM_BITS'(default_taps(NUM_BITS)),
   parameter int                  LOSS_THRESH = 4,
   parameter int                  CNT_W       = 16
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Clear,
   input  logic                i_Data_DV,
   input  logic [NUM_BITS-1:0] i_Data,
   output logic                o_Locked,
   output logic                o_Err,
   output logic [CNT_W-1:0]    o_Err_Count,
   output logic [CNT_W-1:0]    o_Word_Count,
   output logic                o_Period_Done
);

   localparam logic [NUM_BITS-1:0] ALL_ONES  = '1;
   localparam logic [MISS_W-1:0]   MISS_LIMIT = MISS_W'(LOSS_THRESH);

   chk_state_t          state;
   logic [NUM_BITS-1:0] pred;
   logic [NUM_BITS-1:0] seed;
   logic [MISS_W-1:0]   miss_run;

   logic [NUM_BITS-1:0] nxt_data;
   logic [NUM_BITS-1:0] nxt_pred;
   logic [MISS_W-1:0]   miss_next;
   logic                match;
   logic                lock_now;
   logic                word_inc;
   logic                err_inc;
   logic                cnt_clr;

   assign nxt_data  = NUM_BITS'(lfsr_next(32'(i_Data), 32'(TAPS), NUM_BITS));
   assign nxt_pred  = NUM_BITS'(lfsr_next(32'(pred), 32'(TAPS), NUM_BITS));
   assign miss_next = miss_run + MISS_W'(1);
   assign match     = (i_Data == pred);

   // All-ones is the XNOR lockup word and can never start a valid sequence.
   assign lock_now = (state == ACQUIRE) && i_Data_DV && (i_Data != ALL_ONES);
   assign word_inc = (state == CHECK) && i_Data_DV && !i_Clear;
   assign err_inc  = word_inc && !match;
   assign cnt_clr  = i_Clear || lock_now;

   assign o_Locked = (state == CHECK);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L || i_Clear) begin
         state         <= ACQUIRE;
         pred          <= '0;
         seed          <= '0;
         miss_run      <= '0;
         o_Err         <= 1'b0;
         o_Period_Done <= 1'b0;
      end else begin
         o_Err         <= 1'b0;
         o_Period_Done <= 1'b0;
         case (state)
            ACQUIRE: begin
               if (lock_now) begin
                  seed     <= i_Data;
                  pred     <= nxt_data;
                  miss_run <= '0;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (i_Data_DV) begin
                  if (match) begin
                     pred          <= nxt_data;
                     miss_run      <= '0;
                     o_Period_Done <= (i_Data == seed);
                  end else begin
                     // Flywheel on the local sequence so a lone corrupted word cannot re-seed us.
                     pred     <= nxt_pred;
                     miss_run <= miss_next;
                     o_Err    <= 1'b1;
                     if (miss_next == MISS_LIMIT) begin
                        state <= ACQUIRE;
                     end
                  end
               end
            end
            default: state <= ACQUIRE;
         endcase
      end
   end

   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   assign cnt_inc = {err_inc, word_inc};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         sat_counter #(
            .CNT_W (CNT_W)
         ) u_cnt (
            .clk   (i_Clk),
            .rst_l (i_Rst_L),
            .clr   (cnt_clr),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
         );
      end
   endgenerate

   assign o_Word_Count = cnt_val[0];
   assign o_Err_Count  = cnt_val[1];

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Randomized scoreboard bench for lfsr_prbs_checker: a sequence-table reference model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_lfsr_prbs_checker;

   localparam int NB      = 8;
   localparam int CW      = 10;
   localparam int LOSS    = 4;
   localparam int SAT     = (1 << CW) - 1;
   localparam int PERIOD  = 255;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic          clear = 1'b0;
   logic          dv = 1'b0;
   logic [NB-1:0] data = '0;
   logic          locked;
   logic          err;
   logic [CW-1:0] err_count;
   logic [CW-1:0] word_count;
   logic          period_done;

   always #5 clk = ~clk;

   lfsr_prbs_checker #(
      .NUM_BITS    (NB),
      .TAPS        (8'hB8),
      .LOSS_THRESH (LOSS),
      .CNT_W       (CW)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_l),
      .i_Clear       (clear),
      .i_Data_DV     (dv),
      .i_Data        (data),
      .o_Locked      (locked),
      .o_Err         (err),
      .o_Err_Count   (err_count),
      .o_Word_Count  (word_count),
      .o_Period_Done (period_done)
   );

   typedef struct {
      int   txn;
      int   din;
      int   locked;
      int   err;
      int   period;
      int   ec;
      int   wc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_errors = 0;
   int txn_no = 0;
   int period_seen = 0;
   int err_seen = 0;

   // Reference: the maximal sequence as a table plus its inverse index.
   int seq [PERIOD];
   int pos [256];

   int m_locked = 0, m_err = 0, m_period = 0, m_ec = 0, m_wc = 0, m_miss = 0;
   int m_seed = 0, m_idx = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic build_table();
      int s;
      s = 1;
      for (int i = 0; i < 256; i++) pos[i] = -1;
      for (int k = 0; k < PERIOD; k++) begin
         seq[k] = s;
         pos[s] = k;
         s = ((s << 1) & 8'hFE) | (($countones(s & 8'hB8) % 2 == 0) ? 1 : 0);
      end
   endtask

   task automatic model_update(input logic r, input logic c, input logic v, input int d);
      m_err = 0;
      m_period = 0;
      if (!r || c) begin
         m_locked = 0; m_ec = 0; m_wc = 0; m_miss = 0; m_seed = 0;
      end else if (m_locked == 0) begin
         if (v && d != 255) begin
            m_locked = 1; m_seed = d; m_idx = (pos[d] + 1) % PERIOD;
            m_ec = 0; m_wc = 0; m_miss = 0;
         end
      end else if (v) begin
         if (m_wc < SAT) m_wc++;
         if (d == seq[m_idx]) begin
            m_miss = 0;
            m_period = (d == m_seed) ? 1 : 0;
         end else begin
            m_err = 1;
            if (m_ec < SAT) m_ec++;
            m_miss++;
            if (m_miss == LOSS) m_locked = 0;
         end
         m_idx = (m_idx + 1) % PERIOD;
      end
   endtask

   task automatic step(input logic r, input logic c, input logic v, input int d);
      exp_t e;
      rst_l = r;
      clear = c;
      dv    = v;
      data  = NB'(d);
      @(posedge clk);
      model_update(r, c, v, d);
      txn_no++;
      e.txn = txn_no; e.din = d; e.locked = m_locked; e.err = m_err;
      e.period = m_period; e.ec = m_ec; e.wc = m_wc;
      exp_q.push_back(e);
      #1;
   endtask

   function automatic int good_word();
      if (m_locked != 0) return seq[m_idx];
      return int'($urandom_range(0, 254));
   endfunction

   function automatic int bad_word();
      return (good_word() ^ int'($urandom_range(1, 255))) & 255;
   endfunction

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         if (period_done) period_seen++;
         if (err) err_seen++;
         $display("txn %0d din=%02h locked=%0d err=%0d period=%0d ec=%0d wc=%0d",
                  mon_e.txn, mon_e.din, locked, err, period_done, err_count, word_count);
         check("locked", int'(locked), mon_e.locked);
         check("err", int'(err), mon_e.err);
         check("period_done", int'(period_done), mon_e.period);
         check("err_count", int'(err_count), mon_e.ec);
         check("word_count", int'(word_count), mon_e.wc);
      end
   end

   int p0, e0, r;

   initial begin
      build_table();

      // Reset
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h01);
      settle();
      check("rst_locked", int'(locked), 0);
      check("rst_counts", int'(err_count) + int'(word_count), 0);

      // Test 1: clean stream from seed 01, two full periods
      p0 = period_seen;
      step(1'b1, 1'b0, 1'b1, 8'h01);
      for (int i = 0; i < 2 * PERIOD; i++) step(1'b1, 1'b0, 1'b1, good_word());
      settle();
      check("t1_period_pulses", period_seen - p0, 2);
      check("t1_err_count", int'(err_count), 0);
      check("t1_word_count", int'(word_count), 2 * PERIOD);

      // Test 2: single bit-0 flip
      e0 = err_seen;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, good_word());
      step(1'b1, 1'b0, 1'b1, good_word() ^ 1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, good_word());
      settle();
      check("t2_err_pulses", err_seen - e0, 1);
      check("t2_err_count", int'(err_count), 1);
      check("t2_locked", int'(locked), 1);

      // Test 3: loss of lock after LOSS consecutive misses, then relock
      step(1'b1, 1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 1'b1, good_word());
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, good_word());
      for (int i = 0; i < LOSS; i++) step(1'b1, 1'b0, 1'b1, bad_word());
      check("t3_lost_lock", int'(locked), 0);
      check("t3_err_count", int'(err_count), LOSS);
      check("t3_word_count", int'(word_count), 5 + LOSS);
      step(1'b1, 1'b0, 1'b1, good_word());
      check("t3_relocked", int'(locked), 1);
      check("t3_counts_restart", int'(err_count) + int'(word_count), 0);

      // Test 4: lockup word rejected as seed, random DV gaps
      step(1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b1, 8'hFF);
      check("t4_ff_no_lock", int'(locked), 0);
      step(1'b1, 1'b0, 1'b1, 8'h5A);
      check("t4_5a_lock", int'(locked), 1);
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 7));
         for (int g = 0; g < r; g++) step(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 255)));
         step(1'b1, 1'b0, 1'b1, good_word());
      end
      check("t4_err_count", int'(err_count), 0);
      check("t4_word_count", int'(word_count), 300);

      // Test 5: alternating bad/good words drive both counters into saturation
      for (int i = 0; i < SAT + 80; i++) begin
         step(1'b1, 1'b0, 1'b1, bad_word());
         step(1'b1, 1'b0, 1'b1, good_word());
      end
      check("t5_err_sat", int'(err_count), SAT);
      check("t5_word_sat", int'(word_count), SAT);
      check("t5_locked", int'(locked), 1);

      // Test 6: reset and clear mid-CHECK with DV high
      step(1'b0, 1'b0, 1'b1, good_word());
      check("t6_rst_locked", int'(locked), 0);
      check("t6_rst_words", int'(word_count), 0);
      step(1'b1, 1'b0, 1'b1, 8'h33);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, good_word());
      step(1'b1, 1'b1, 1'b1, good_word());
      check("t6_clr_locked", int'(locked), 0);
      check("t6_clr_words", int'(word_count), 0);

      // Random mix
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2)       step(1'b1, 1'b1, 1'($urandom_range(0, 1)), good_word());
         else if (r < 35) step(1'b1, 1'b0, 1'b0, int'($urandom_range(0, 255)));
         else if (r < 75) step(1'b1, 1'b0, 1'b1, good_word());
         else if (r < 92) step(1'b1, 1'b0, 1'b1, bad_word());
         else             step(1'b1, 1'b0, 1'b1, 8'hFF);
      end

      settle();
      check("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
